// File: rtl/fact_arbiter.sv
// Two-requester round-robin front end for a factorial core: grants one job at a time,
// latches its operand, watches the core with a WAIT timeout and returns a done pulse.
module fact_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] n0,
  input  logic [31:0] n1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        err,
  output logic        tmo,
  output logic        busy,
  output logic        owner,
  output logic        core_go,
  output logic [31:0] core_n,
  input  logic        core_done,
  input  logic        core_error,
  input  logic [31:0] core_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GO   = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 32'd1);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] opnd_q, opnd_d;
  logic        owner_q, owner_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic        go_q, go_d;
  logic        busy_q, busy_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        grant_s;

  // State and output registers, cleared asynchronously so a reset mid-job drops it silently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      cnt_q    <= 16'd0;
      opnd_q   <= 32'd0;
      owner_q  <= 1'b0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  // Next-state, arbitration, operand latch, timeout count and result capture
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    owner_d  = owner_q;
    result_d = result_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    // ptr_q names the requester preferred on a tie; it flips away from whoever is granted
    grant_s  = (req0 && req1) ? ptr_q : req1;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_GO;
          owner_d = grant_s;
          ptr_d   = ~grant_s;
          opnd_d  = grant_s ? n1 : n0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GO: begin
        state_d = S_WAIT;
        cnt_d   = 16'd0;
      end
      S_WAIT: begin
        if (core_done || core_error) begin
          state_d  = S_RESP;
          result_d = core_result;
          err_d    = core_error;
          tmo_d    = 1'b0;
        end else if (cnt_q == TMO_LAST) begin
          state_d  = S_RESP;
          result_d = 32'd0;
          err_d    = 1'b1;
          tmo_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flops are loaded from the upcoming state so each pulse lines up with its state
  always_comb begin
    go_d    = (state_d == S_GO);
    busy_d  = (state_d != S_IDLE);
    done0_d = (state_d == S_RESP) && (owner_d == 1'b0);
    done1_d = (state_d == S_RESP) && (owner_d == 1'b1);
  end

  assign done0   = done0_q;
  assign done1   = done1_q;
  assign result  = result_q;
  assign err     = err_q;
  assign tmo     = tmo_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign core_go = go_q;
  assign core_n  = opnd_q;

endmodule

// File: tb/tb_fact_arbiter.sv
// Directed bench for fact_arbiter (TIMEOUT=8): the bench plays both requesters and the
// factorial core, with hand-computed results for every job.
module tb_fact_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [31:0] n0, n1;
  logic        done0, done1;
  logic [31:0] result;
  logic        err, tmo, busy, owner, core_go;
  logic [31:0] core_n;
  logic        core_done, core_error;
  logic [31:0] core_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fact_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .n0(n0), .n1(n1),
    .done0(done0), .done1(done1), .result(result), .err(err), .tmo(tmo),
    .busy(busy), .owner(owner), .core_go(core_go), .core_n(core_n),
    .core_done(core_done), .core_error(core_error), .core_result(core_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done0"}, done0, 32'd0);
    check({tag, "_done1"}, done1, 32'd0);
    check({tag, "_go"}, core_go, 32'd0);
    check({tag, "_n"}, core_n, 32'd0);
    check({tag, "_res"}, result, 32'd0);
    check({tag, "_err"}, err, 32'd0);
    check({tag, "_tmo"}, tmo, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    check({tag, "_own"}, owner, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; n0 = 32'd0; n1 = 32'd0;
    core_done = 1'b0; core_error = 1'b0; core_result = 32'd0;
    step();
    step();
    rst = 1'b1;
  endtask

  // One job end to end: find core_go, act as core, then check the done cycle.
  task automatic serve(input string tag, input bit exp_own, input logic [31:0] exp_n,
                       input bit resp, input int delay, input bit cd, input bit ce,
                       input logic [31:0] cres, input logic [31:0] exp_res,
                       input bit exp_err, input bit exp_tmo, input int exp_wait,
                       input bit drop);
    bit seen;
    int waited;
    int extra_go;
    logic [31:0] s0, s1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (core_go) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_gofound"}, seen, 32'd1);
    check({tag, "_owner"}, owner, exp_own);
    check({tag, "_core_n"}, core_n, exp_n);
    check({tag, "_busy"}, busy, 32'd1);
    s0 = n0; s1 = n1;
    n0 = 32'hFFFF_FFFF; n1 = 32'hFFFF_FFFF;
    step();
    check({tag, "_go_low"}, core_go, 32'd0);
    waited = 0;
    extra_go = 0;
    while (!(done0 || done1) && waited < 30) begin
      if (resp && waited == delay) begin
        core_done = cd; core_error = ce; core_result = cres;
      end
      step();
      core_done = 1'b0; core_error = 1'b0;
      if (core_go) extra_go++;
      waited++;
    end
    check({tag, "_latency"}, waited, exp_wait);
    check({tag, "_extra_go"}, extra_go, 32'd0);
    check({tag, "_done0"}, done0, (exp_own == 1'b0) ? 32'd1 : 32'd0);
    check({tag, "_done1"}, done1, (exp_own == 1'b1) ? 32'd1 : 32'd0);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_tmo"}, tmo, exp_tmo);
    check({tag, "_n_held"}, core_n, exp_n);
    n0 = s0; n1 = s1;
    if (drop) begin
      if (exp_own) req1 = 1'b0;
      else req0 = 1'b0;
    end
    step();
    check({tag, "_done0_off"}, done0, 32'd0);
    check({tag, "_done1_off"}, done1, 32'd0);
    check({tag, "_idle"}, busy, 32'd0);
  endtask

  initial begin
    int hits;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; n0 = 32'd0; n1 = 32'd0;
    core_done = 1'b0; core_error = 1'b0; core_result = 32'd0;
    #1;
    check_all_zero("rst");
    do_reset();

    // Tie right after reset: requester 0 first, then 1
    req0 = 1'b1; req1 = 1'b1; n0 = 32'd12; n1 = 32'd3;
    serve("tie0", 1'b0, 32'd12, 1'b1, 3, 1'b1, 1'b0, 32'd479001600, 32'd479001600,
          1'b0, 1'b0, 4, 1'b1);
    serve("tie1", 1'b1, 32'd3, 1'b1, 2, 1'b1, 1'b0, 32'd6, 32'd6, 1'b0, 1'b0, 3, 1'b1);

    req0 = 1'b1; n0 = 32'd5;
    serve("f5", 1'b0, 32'd5, 1'b1, 5, 1'b1, 1'b0, 32'd120, 32'd120, 1'b0, 1'b0, 6, 1'b1);

    req1 = 1'b1; n1 = 32'd13;
    serve("cerr", 1'b1, 32'd13, 1'b1, 4, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
          1'b1, 1'b0, 5, 1'b1);

    req0 = 1'b1; n0 = 32'd7;
    serve("dne", 1'b0, 32'd7, 1'b1, 1, 1'b1, 1'b1, 32'd5040, 32'd5040, 1'b1, 1'b0, 2, 1'b1);

    req1 = 1'b1; n1 = 32'd9;
    serve("tmo", 1'b1, 32'd9, 1'b0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 8, 1'b1);

    // Core status while idle must not start or capture anything
    core_done = 1'b1; core_error = 1'b1; core_result = 32'd123;
    step();
    core_done = 1'b0; core_error = 1'b0;
    step();
    check("stray_busy", busy, 32'd0);
    check("stray_res", result, 32'd0);
    check("stray_tmo", tmo, 32'd1);

    // Continuous requests alternate
    do_reset();
    req0 = 1'b1; req1 = 1'b1; n0 = 32'd4; n1 = 32'd5;
    serve("rr0", 1'b0, 32'd4, 1'b1, 2, 1'b1, 1'b0, 32'd24, 32'd24, 1'b0, 1'b0, 3, 1'b0);
    serve("rr1", 1'b1, 32'd5, 1'b1, 2, 1'b1, 1'b0, 32'd120, 32'd120, 1'b0, 1'b0, 3, 1'b0);
    serve("rr2", 1'b0, 32'd4, 1'b1, 0, 1'b1, 1'b0, 32'd24, 32'd24, 1'b0, 1'b0, 1, 1'b0);
    serve("rr3", 1'b1, 32'd5, 1'b1, 1, 1'b1, 1'b0, 32'd120, 32'd120, 1'b0, 1'b0, 2, 1'b1);
    req0 = 1'b0;
    step();
    check("rr_quiet", busy, 32'd0);

    // Reset pulled during WAIT
    req0 = 1'b1; n0 = 32'd6;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (core_go) break;
    end
    check("mid_go", core_go, 32'd1);
    step();
    step();
    step();
    check("mid_busy", busy, 32'd1);
    rst = 1'b0; req0 = 1'b0;
    #1;
    check_all_zero("mid");
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done0 || done1 || core_go || busy) hits++;
    end
    check("post_rst_quiet", hits, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
